sensor_test_packet_gen: RTL and testbench



---
 rtl/sensor_test_pkg.sv | 14 +
 rtl/test_channel_gen.sv | 49 ++++
 rtl/sensor_test_packet_gen.sv | 76 +++++++
 tb/tb_sensor_test_packet_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sensor_test_pkg.sv
// rtl/sensor_test_pkg.sv - shared encodings for the synthetic sensor packet source
package sensor_test_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP     = 2'd0,
    MODE_SAWTOOTH = 2'd1,
    MODE_CONST    = 2'd2,
    MODE_DOWN     = 2'd3
  } mode_e;

  localparam logic [7:0] DEFAULT_ID_BYTE = 8'h4D;
  localparam int         DROP_W          = 8;

endpackage

// File: rtl/test_channel_gen.sv
// rtl/test_channel_gen.sv - one channel's value register and test-pattern stepping
module test_channel_gen
  import sensor_test_pkg::*;
#(
  parameter int                  CH_WIDTH = 16,
  parameter logic [CH_WIDTH-1:0] SEED     = '0,
  parameter int                  RAMP_MAX = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  mode_e               mode,
  input  logic                mode_changed,
  output logic [CH_WIDTH-1:0] cur_val,
  output logic [CH_WIDTH-1:0] pkt_val
);

  localparam logic [CH_WIDTH-1:0] LIMIT = CH_WIDTH'(RAMP_MAX);
  localparam logic [CH_WIDTH-1:0] ONE   = CH_WIDTH'(1);

  logic [CH_WIDTH-1:0] val;
  logic [CH_WIDTH-1:0] base;
  logic [CH_WIDTH-1:0] next_val;

  // A mode change restarts the pattern from the seed on this very tick.
  assign base = mode_changed ? SEED : val;

  always_comb begin
    next_val = base;
    unique case (mode)
      MODE_RAMP:     next_val = base + ONE;
      MODE_SAWTOOTH: next_val = (base >= LIMIT) ? SEED : base + ONE;
      MODE_CONST:    next_val = base;
      MODE_DOWN:     next_val = base - ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= SEED;
    end else if (tick) begin
      val <= next_val;
    end
  end

  assign cur_val = val;
  assign pkt_val = base;

endmodule

// File: rtl/sensor_test_packet_gen.sv
// rtl/sensor_test_packet_gen.sv - synthetic multi-channel sensor packet source with
// valid/ready hold and saturating overrun counter
module sensor_test_packet_gen
  import sensor_test_pkg::*;
#(
  parameter int          NUM_CH     = 3,
  parameter int          CH_WIDTH   = 16,
  parameter int          TS_WIDTH   = 24,
  parameter logic [7:0]  ID_BYTE    = DEFAULT_ID_BYTE,
  parameter int          CH_SPACING = 50,
  parameter int          RAMP_MAX   = 1000,
  localparam int         PKT_W      = NUM_CH*CH_WIDTH + TS_WIDTH + 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SAMPLE_TICK,
  input  logic [1:0]          MODE,
  input  logic [TS_WIDTH-1:0] TIMESTAMP,
  output logic [PKT_W-1:0]    PKT_DATA,
  output logic                PKT_VALID,
  input  logic                PKT_READY,
  output logic [DROP_W-1:0]   DROP_COUNT
);

  mode_e                      mode_in;
  mode_e                      last_mode;
  logic                       mode_changed;
  logic                       load;
  logic [NUM_CH*CH_WIDTH-1:0] chans;
  logic [CH_WIDTH-1:0]        cur_vals [NUM_CH];

  assign mode_in      = mode_e'(MODE);
  assign mode_changed = (mode_in != last_mode);
  assign load         = SAMPLE_TICK && (!PKT_VALID || PKT_READY);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    test_channel_gen #(
      .CH_WIDTH (CH_WIDTH),
      .SEED     (CH_WIDTH'(g * CH_SPACING)),
      .RAMP_MAX (RAMP_MAX)
    ) u_ch (
      .clk          (CLK),
      .rst          (RESET),
      .tick         (SAMPLE_TICK),
      .mode         (mode_in),
      .mode_changed (mode_changed),
      .cur_val      (cur_vals[g]),
      .pkt_val      (chans[g*CH_WIDTH +: CH_WIDTH])
    );
  end

  // Channels keep stepping on a dropped tick so the pattern stays time-true.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_mode  <= MODE_RAMP;
      PKT_DATA   <= '0;
      PKT_VALID  <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      if (SAMPLE_TICK) begin
        last_mode <= mode_in;
      end
      if (load) begin
        PKT_DATA  <= {chans, TIMESTAMP, ID_BYTE};
        PKT_VALID <= 1'b1;
      end else if (SAMPLE_TICK) begin
        if (DROP_COUNT != '1) begin
          DROP_COUNT <= DROP_COUNT + DROP_W'(1);
        end
      end else if (PKT_VALID && PKT_READY) begin
        PKT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_test_packet_gen.sv
// tb/tb_sensor_test_packet_gen.sv - directed and randomized bench against a reference model
module tb_sensor_test_packet_gen;

  localparam int NUM_CH   = 3;
  localparam int RAMP_MAX = 105;
  localparam int PKT_W    = NUM_CH*16 + 24 + 8;

  logic             CLK;
  logic             RESET;
  logic             SAMPLE_TICK;
  logic [1:0]       MODE;
  logic [23:0]      TIMESTAMP;
  logic [PKT_W-1:0] PKT_DATA;
  logic             PKT_VALID;
  logic             PKT_READY;
  logic [7:0]       DROP_COUNT;

  sensor_test_packet_gen #(
    .NUM_CH(NUM_CH), .CH_WIDTH(16), .TS_WIDTH(24), .ID_BYTE(8'h4D),
    .CH_SPACING(50), .RAMP_MAX(RAMP_MAX)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .MODE(MODE),
    .TIMESTAMP(TIMESTAMP), .PKT_DATA(PKT_DATA), .PKT_VALID(PKT_VALID),
    .PKT_READY(PKT_READY), .DROP_COUNT(DROP_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int               checks = 0;
  int               errors = 0;
  int               m_val [NUM_CH];
  int               m_last;
  logic [PKT_W-1:0] m_data;
  logic             m_valid;
  int               m_drop;

  function automatic int seed(int i);
    return (i * 50) % 65536;
  endfunction

  function automatic int adv(int v, int s, int md);
    case (md)
      0:       return (v + 1) % 65536;
      1:       return (v >= RAMP_MAX) ? s : v + 1;
      2:       return v;
      default: return (v + 65535) % 65536;
    endcase
  endfunction

  function automatic logic [15:0] ch(int i);
    return PKT_DATA[32 + 16*i +: 16];
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_data"},  128'(PKT_DATA),   128'(m_data));
    check({tag, "_valid"}, 128'(PKT_VALID),  128'(m_valid));
    check({tag, "_drops"}, 128'(DROP_COUNT), 128'(m_drop));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_val[i] = seed(i);
    m_last  = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_step(bit tick, int md, logic [23:0] ts, bit rdy);
    logic [PKT_W-1:0] p;
    int               base;
    if (tick) begin
      p = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        base = (md != m_last) ? seed(i) : m_val[i];
        p = (p << 16) | PKT_W'(base);
        m_val[i] = adv(base, seed(i), md);
      end
      p = (p << 32) | PKT_W'({ts, 8'h4D});
      if (!m_valid || rdy) begin
        m_data  = p;
        m_valid = 1'b1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
      m_last = md;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(bit tick, int md, logic [23:0] ts, bit rdy);
    SAMPLE_TICK = tick;
    MODE        = md[1:0];
    TIMESTAMP   = ts;
    PKT_READY   = rdy;
    @(posedge CLK);
    model_step(tick, md, ts, rdy);
    @(negedge CLK);
    SAMPLE_TICK = 1'b0;
    check_model("cyc");
  endtask

  task automatic do_reset();
    RESET       = 1'b1;
    SAMPLE_TICK = 1'b0;
    PKT_READY   = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int cur_md;
    RESET = 1'b1; SAMPLE_TICK = 1'b0; MODE = 2'd0; TIMESTAMP = '0; PKT_READY = 1'b0;
    @(negedge CLK);
    do_reset();

    cycle(1, 0, 24'h000010, 1);
    check("first_pkt", 128'(PKT_DATA), 128'({16'd100, 16'd50, 16'd0, 24'h000010, 8'h4D}));
    check("first_valid", 128'(PKT_VALID), 128'(1));
    cycle(1, 0, 24'h000011, 1);
    check("second_pkt", 128'(PKT_DATA), 128'({16'd101, 16'd51, 16'd1, 24'h000011, 8'h4D}));

    do_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(1, 1, 24'(k), 1);
      check("saw_ch2", 128'(ch(2)), 128'((k < 6) ? 100 + k : 100));
      check("saw_ch0", 128'(ch(0)), 128'(k));
    end

    do_reset();
    cycle(1, 3, 24'h1, 1);
    check("down_ch0_a", 128'(ch(0)), 128'(16'd0));
    check("down_ch1_a", 128'(ch(1)), 128'(16'd50));
    cycle(1, 3, 24'h2, 1);
    check("down_ch0_b", 128'(ch(0)), 128'(16'hFFFF));
    check("down_ch1_b", 128'(ch(1)), 128'(16'd49));

    do_reset();
    cycle(1, 0, 24'h000020, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 24'(33 + k), 0);
    check("hold_valid", 128'(PKT_VALID), 128'(1));
    check("hold_data", 128'(PKT_DATA), 128'({16'd100, 16'd50, 16'd0, 24'h000020, 8'h4D}));
    check("hold_drops", 128'(DROP_COUNT), 128'(3));
    cycle(1, 0, 24'h000030, 1);
    check("accept_tick_data", 128'(PKT_DATA), 128'({16'd104, 16'd54, 16'd4, 24'h000030, 8'h4D}));
    check("accept_tick_valid", 128'(PKT_VALID), 128'(1));
    for (int k = 0; k < 300; k++) cycle(1, 0, 24'(k), 0);
    check("drop_sat", 128'(DROP_COUNT), 128'(255));

    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 0, 24'(k), 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 2, 24'h000040, 1);
      check("const_seeds", 128'(PKT_DATA), 128'({16'd100, 16'd50, 16'd0, 24'h000040, 8'h4D}));
    end

    SAMPLE_TICK = 1'b0; PKT_READY = 1'b0;
    @(posedge CLK);
    model_step(0, 2, 24'h0, 0);
    #2 RESET = 1'b1;
    #1;
    check("midrst_valid", 128'(PKT_VALID), 128'(0));
    check("midrst_data", 128'(PKT_DATA), 128'(0));
    check("midrst_drops", 128'(DROP_COUNT), 128'(0));
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    cycle(1, 0, 24'h000055, 1);
    check("post_rst_seeds", 128'(PKT_DATA), 128'({16'd100, 16'd50, 16'd0, 24'h000055, 8'h4D}));

    cur_md = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) cur_md = int'($urandom_range(0, 3));
      cycle(bit'($urandom_range(0, 1)), cur_md, 24'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
